// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter granting one of 16 requesters,
// with one-hot decoded grant and bounded tenure.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        rel,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] y,
  output logic        expire
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state;
  logic [3:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic       found;
  logic [3:0] win;
  logic [3:0] cand;
  logic       timeout;
  logic       owner_req;
  logic       release_evt;

  // Search req starting at ptr, wrapping mod 16.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    owner_req   = req[gnt_idx];
    timeout     = HOLD_EN && (cnt == HOLD_LAST);
    release_evt = rel || !owner_req || timeout;
  end

  // Grant FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      y         <= '0;
      expire    <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      expire <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt_valid <= 1'b1;
            gnt_idx   <= win;
            y         <= 16'(16'h1 << win);
            cnt       <= '0;
            ptr       <= win + 4'd1;
          end
        end
        GRANT: begin
          if (release_evt) begin
            expire <= timeout && !rel && owner_req;
            cnt    <= '0;
            if (found) begin
              gnt_idx <= win;
              y       <= 16'(16'h1 << win);
              ptr     <= win + 4'd1;
            end else begin
              state     <= IDLE;
              gnt_valid <= 1'b0;
              y         <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
